// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared state encoding, widths and letter patterns for the Morse encoder
package morse_pkg;

    localparam int PAT_W = 12;
    localparam int LEN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // Patterns are MSB-first and left-justified; dot=1, dash=111, gap=0.
    localparam logic [PAT_W-1:0] PAT_A = 12'b1011_1000_0000;
    localparam logic [PAT_W-1:0] PAT_B = 12'b1110_1010_1000;
    localparam logic [PAT_W-1:0] PAT_C = 12'b1110_1011_1010;
    localparam logic [PAT_W-1:0] PAT_D = 12'b1110_1010_0000;
    localparam logic [PAT_W-1:0] PAT_E = 12'b1000_0000_0000;
    localparam logic [PAT_W-1:0] PAT_F = 12'b1010_1110_1000;
    localparam logic [PAT_W-1:0] PAT_G = 12'b1110_1110_1000;
    localparam logic [PAT_W-1:0] PAT_H = 12'b1010_1010_0000;

    localparam logic [LEN_W-1:0] LEN_A = 4'd5;
    localparam logic [LEN_W-1:0] LEN_B = 4'd9;
    localparam logic [LEN_W-1:0] LEN_C = 4'd11;
    localparam logic [LEN_W-1:0] LEN_D = 4'd7;
    localparam logic [LEN_W-1:0] LEN_E = 4'd1;
    localparam logic [LEN_W-1:0] LEN_F = 4'd9;
    localparam logic [LEN_W-1:0] LEN_G = 4'd9;
    localparam logic [LEN_W-1:0] LEN_H = 4'd7;

endpackage

// File: rtl/morse_rom.sv
// rtl/morse_rom.sv - combinational letter-to-pattern lookup for letters A..H
module morse_rom
    import morse_pkg::*;
(
    input  logic [2:0]       letter_sel,
    output logic [PAT_W-1:0] pattern,
    output logic [LEN_W-1:0] len
);

    always_comb begin
        pattern = PAT_A;
        len     = LEN_A;
        case (letter_sel)
            3'd0: begin pattern = PAT_A; len = LEN_A; end
            3'd1: begin pattern = PAT_B; len = LEN_B; end
            3'd2: begin pattern = PAT_C; len = LEN_C; end
            3'd3: begin pattern = PAT_D; len = LEN_D; end
            3'd4: begin pattern = PAT_E; len = LEN_E; end
            3'd5: begin pattern = PAT_F; len = LEN_F; end
            3'd6: begin pattern = PAT_G; len = LEN_G; end
            3'd7: begin pattern = PAT_H; len = LEN_H; end
            default: begin pattern = PAT_A; len = LEN_A; end
        endcase
    end

endmodule

// File: rtl/morse_encoder.sv
// rtl/morse_encoder.sv - serialises one Morse letter onto a LED, one bit per divider tick
module morse_encoder
    import morse_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [2:0] letter_sel,
    output logic       led,
    output logic       busy,
    output logic       done
);

    state_t            state_q, state_d;
    logic [PAT_W-1:0]  shreg_q, shreg_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_q;
    logic              start_edge;
    logic [PAT_W-1:0]  rom_pattern;
    logic [LEN_W-1:0]  rom_len;

    morse_rom u_rom (
        .letter_sel (letter_sel),
        .pattern    (rom_pattern),
        .len        (rom_len)
    );

    assign start_edge = start & ~start_q;

    // start_q resets high so a start held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                led_d  = 1'b0;
                busy_d = 1'b0;
                if (start_edge) begin
                    shreg_d = rom_pattern;
                    cnt_d   = rom_len;
                    busy_d  = 1'b1;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (tick) begin
                    led_d   = shreg_q[PAT_W-1];
                    shreg_d = {shreg_q[PAT_W-2:0], 1'b0};
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tick) begin
                    if (cnt_q != '0) begin
                        led_d   = shreg_q[PAT_W-1];
                        shreg_d = {shreg_q[PAT_W-2:0], 1'b0};
                        cnt_d   = cnt_q - LEN_W'(1);
                    end else begin
                        led_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
